display_controle: RTL and testbench
===================================

DISPLAY_CONTROLE -- requirements
Module: display_controle

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 16: consecutive stable cycles required to accept a button level change (on-board build overrides to 500000).
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port res_valid, input, 1: one-cycle strobe, ALU result present.
REQ-005 SHALL have port res_data, input, 16: ALU result (quotient for division).
REQ-006 SHALL have port res_resto, input, 8: division remainder.
REQ-007 SHALL have port res_div, input, 1: result came from a division.
REQ-008 SHALL have port res_erro, input, 1: ALU error (division by zero).
REQ-009 SHALL have port clr, input, 1: synchronous clear request.
REQ-010 SHALL have port btn_base, input, 1: raw, asynchronous base-select button, 1 = pressed.
REQ-011 SHALL have port Data, output, 16: held result for the result display stage.
REQ-012 SHALL have port Resto, output, 8: held remainder for the remainder display stage.
REQ-013 SHALL have port sel, output, 2: base code (11 decimal, 01 hexadecimal, 10 octal).
REQ-014 SHALL have port resto_en, output, 1: enables the remainder display.
REQ-015 SHALL have port erro, output, 1: error indicator.
REQ-016 SHALL have port upd, output, 1: one-cycle pulse when held values change.

Function
REQ-017 On res_valid=1, SHALL register Data<=res_data, Resto<=res_resto, resto_en<=res_div & ~res_erro, erro<=res_erro; all visible on the next clock edge (latency 1).
REQ-018 When res_erro=1 with res_valid, SHALL force Data=0 and Resto=0 and set erro.
REQ-019 erro SHALL stay set until the next res_valid without error, or clr.
REQ-020 With no res_valid and no clr, all held outputs SHALL keep their values indefinitely.
REQ-021 clr=1 SHALL zero Data, Resto, resto_en and erro on the next edge; sel SHALL NOT change.
REQ-022 clr and res_valid in the same cycle: clr SHALL win and the result is discarded.
REQ-023 upd SHALL pulse for exactly one cycle, the cycle after any accepted res_valid or clr.
REQ-024 btn_base SHALL pass through a 2-flop synchronizer before any other use.
REQ-025 The debouncer SHALL accept a new level only after DEBOUNCE_CYC consecutive cycles equal to the candidate level; any mismatch SHALL restart the count.
REQ-026 Each accepted 0->1 transition SHALL advance the base FSM exactly once; a held press SHALL NOT auto-repeat.
REQ-027 The base FSM SHALL have states DEC (sel=11), HEX (01) and OCT (10), advancing DEC->HEX->OCT->DEC and wrapping.
REQ-028 sel SHALL never take the value 00; an illegal state SHALL recover to DEC on the next edge.
REQ-029 A base advance coinciding with res_valid or clr SHALL have both effects applied in the same cycle.
REQ-030 The debounce counter SHALL saturate and never wrap.

Reset
REQ-031 rst_n=0 SHALL immediately set Data=0, Resto=0, resto_en=0, erro=0, upd=0, sel=11 (DEC), debouncer level=0, count=0 and synchronizer flops=0.
REQ-032 Reset asserted mid-debounce or mid-press SHALL discard the press; after release, a still-held button SHALL NOT advance until it has been released and pressed again.

Structure
REQ-033 A shared package SHALL hold the base-code constants BASE_DEC=11, BASE_HEX=01, BASE_OCT=10 and the FSM state encoding.
REQ-034 The synchronizer and debouncer SHALL be one sub-module, debounce_botao, outputting a one-cycle rise pulse.
REQ-035 Data, Resto, sel and resto_en SHALL drive the downstream 7-segment display stages directly, with no further glue logic.

Verification
REQ-036 Reset, then res_valid with res_data=0x00C8, res_resto=0x07, res_div=1 -> next cycle Data=0x00C8, Resto=0x07, resto_en=1, erro=0, upd pulses once.
REQ-037 res_valid with res_erro=1, res_data=0x1234 -> Data=0, Resto=0, erro=1, resto_en=0; a later valid without error -> erro=0.
REQ-038 Three clean presses, each held 20 cycles, DEBOUNCE_CYC=16 -> sel goes 11->01->10->11, one step per press.
REQ-039 Button bouncing every 5 cycles for 100 cycles, then stable high for 16 cycles -> exactly one advance.
REQ-040 clr and res_valid in the same cycle -> all held values zero, upd=1 for one cycle, sel unchanged.
REQ-041 rst_n pulsed low while the button is held and sel=01 -> sel=11 at once; no advance until the button is released and pressed again.

Source files
------------

// File: rtl/display_controle_pkg.sv
// Shared base-code constants and base-selection FSM encoding.
package display_controle_pkg;

  // Base codes seen by the 7-segment stages; 2'b00 is never legal.
  localparam logic [1:0] BASE_DEC = 2'b11;
  localparam logic [1:0] BASE_HEX = 2'b01;
  localparam logic [1:0] BASE_OCT = 2'b10;

  // State encoding equals the base code so sel is the state register itself.
  typedef enum logic [1:0] {
    StDec = BASE_DEC,
    StHex = BASE_HEX,
    StOct = BASE_OCT
  } base_state_e;

endpackage

// File: rtl/debounce_botao.sv
// Button synchronizer + debouncer; emits a one-cycle pulse per accepted press.
// After reset the debouncer is disarmed: a press is only reported once a
// released level has been seen for DEBOUNCE_CYC cycles, so a button held
// through reset never produces a step.
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            r_sync0;
  logic            r_sync1;
  logic            r_level;
  logic            r_armed;
  logic            r_rise;
  logic [CntW-1:0] r_cnt;

  logic            w_cand;
  logic            w_accept;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
    end
  end

  // Count while the input differs from the accepted level, or while disarmed
  // and sitting released (this is what arms the debouncer).
  always_comb begin
    w_cand   = (r_sync1 != r_level) | (~r_armed & ~r_sync1);
    w_accept = w_cand & (r_cnt == CntLast);
  end

  // Debounce counter, accepted level, arm flag and registered rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (!w_cand) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync1;
        if (!r_sync1) begin
          r_armed <= 1'b1;
        end else if (r_armed) begin
          r_rise <= 1'b1;
        end
      end else if (r_cnt != CntLast) begin
        // Saturate: never wraps even if the compare were ever missed.
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/display_controle.sv
// Holds the last ALU result for the display stages and cycles the display
// base (DEC -> HEX -> OCT) on debounced button presses.
module display_controle
  import display_controle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  input  logic [7:0]  res_resto,
  input  logic        res_div,
  input  logic        res_erro,
  input  logic        clr,
  input  logic        btn_base,
  output logic [15:0] Data,
  output logic [7:0]  Resto,
  output logic [1:0]  sel,
  output logic        resto_en,
  output logic        erro,
  output logic        upd
);

  logic [15:0] r_data;
  logic [7:0]  r_resto;
  logic        r_resto_en;
  logic        r_erro;
  logic        r_upd;
  base_state_e r_state;
  base_state_e w_state_next;
  logic        w_rise;

  debounce_botao #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .i_btn (btn_base),
    .o_rise(w_rise)
  );

  // Result holding registers; clr wins over a simultaneous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_resto    <= '0;
      r_resto_en <= 1'b0;
      r_erro     <= 1'b0;
      r_upd      <= 1'b0;
    end else begin
      r_upd <= clr | res_valid;
      if (clr) begin
        r_data     <= '0;
        r_resto    <= '0;
        r_resto_en <= 1'b0;
        r_erro     <= 1'b0;
      end else if (res_valid) begin
        r_data     <= res_erro ? 16'h0000 : res_data;
        r_resto    <= res_erro ? 8'h00 : res_resto;
        r_resto_en <= res_div & ~res_erro;
        r_erro     <= res_erro;
      end
    end
  end

  // Base FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StDec;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Base FSM next state; any illegal encoding falls back to DEC.
  always_comb begin
    w_state_next = StDec;
    unique case (r_state)
      StDec:   w_state_next = w_rise ? StHex : StDec;
      StHex:   w_state_next = w_rise ? StOct : StHex;
      StOct:   w_state_next = w_rise ? StDec : StOct;
      default: w_state_next = StDec;
    endcase
  end

  assign Data     = r_data;
  assign Resto    = r_resto;
  assign resto_en = r_resto_en;
  assign erro     = r_erro;
  assign upd      = r_upd;
  assign sel      = r_state;

endmodule

// File: tb/tb_display_controle.sv
// Directed bench for display_controle: result holding, clear, base cycling,
// bounce rejection and reset-while-held behaviour.
module tb_display_controle;

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic [15:0] res_data;
  logic [7:0]  res_resto;
  logic        res_div;
  logic        res_erro;
  logic        clr;
  logic        btn_base;
  logic [15:0] Data;
  logic [7:0]  Resto;
  logic [1:0]  sel;
  logic        resto_en;
  logic        erro;
  logic        upd;

  int n_checks;
  int n_errors;

  display_controle #(
    .DEBOUNCE_CYC(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_resto(res_resto),
    .res_div  (res_div),
    .res_erro (res_erro),
    .clr      (clr),
    .btn_base (btn_base),
    .Data     (Data),
    .Resto    (Resto),
    .sel      (sel),
    .resto_en (resto_en),
    .erro     (erro),
    .upd      (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One result strobe, driven at a negedge; returns at the next negedge.
  task automatic send_res(input logic [15:0] d, input logic [7:0] r, input logic dv,
                          input logic er, input logic c);
    res_valid = 1'b1;
    res_data  = d;
    res_resto = r;
    res_div   = dv;
    res_erro  = er;
    clr       = c;
    @(negedge clk);
    res_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic press(input int hi, input int lo);
    btn_base = 1'b1;
    wait_cyc(hi);
    btn_base = 1'b0;
    wait_cyc(lo);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_resto = '0;
    res_div   = 1'b0;
    res_erro  = 1'b0;
    clr       = 1'b0;
    btn_base  = 1'b0;

    // Reset state
    wait_cyc(2);
    check_eq("rst_data", Data, 32'h0);
    check_eq("rst_resto", Resto, 32'h0);
    check_eq("rst_sel", sel, 32'h3);
    check_eq("rst_flags", {resto_en, erro, upd}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(25);

    // Division result
    send_res(16'h00C8, 8'h07, 1'b1, 1'b0, 1'b0);
    check_eq("div_data", Data, 32'h00C8);
    check_eq("div_resto", Resto, 32'h07);
    check_eq("div_resto_en", resto_en, 32'h1);
    check_eq("div_erro", erro, 32'h0);
    check_eq("div_upd", upd, 32'h1);
    wait_cyc(1);
    check_eq("div_upd_off", upd, 32'h0);
    wait_cyc(10);
    check_eq("div_hold", {Data, Resto}, 32'h00C807);

    // Error result forces zeros, error sticks until a clean result
    send_res(16'h1234, 8'h55, 1'b1, 1'b1, 1'b0);
    check_eq("err_vals", {Data, Resto, resto_en}, 32'h0);
    check_eq("err_flag", erro, 32'h1);
    wait_cyc(5);
    check_eq("err_sticky", erro, 32'h1);
    send_res(16'h00AB, 8'h11, 1'b0, 1'b0, 1'b0);
    check_eq("clean_erro", erro, 32'h0);
    check_eq("clean_data", Data, 32'h00AB);
    check_eq("clean_resto_en", resto_en, 32'h0);

    // Three clean presses
    press(20, 20);
    check_eq("press1_sel", sel, 32'h1);
    press(20, 20);
    check_eq("press2_sel", sel, 32'h2);
    press(20, 20);
    check_eq("press3_sel", sel, 32'h3);

    // Bounce for 100 cycles, then stable high; held press must not repeat
    for (int i = 0; i < 20; i++) begin
      btn_base = ~i[0];
      wait_cyc(5);
    end
    check_eq("bounce_nostep", sel, 32'h3);
    btn_base = 1'b1;
    wait_cyc(60);
    check_eq("bounce_one_step", sel, 32'h1);
    btn_base = 1'b0;
    wait_cyc(25);
    check_eq("release_nostep", sel, 32'h1);

    // clr beats a simultaneous result; sel unaffected
    send_res(16'h5555, 8'h66, 1'b1, 1'b0, 1'b0);
    check_eq("pre_clr_data", Data, 32'h5555);
    send_res(16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    check_eq("clr_vals", {Data, Resto, resto_en, erro}, 32'h0);
    check_eq("clr_upd", upd, 32'h1);
    check_eq("clr_sel", sel, 32'h1);
    wait_cyc(1);
    check_eq("clr_upd_off", upd, 32'h0);

    // Reset while the button is held at sel=01
    press(20, 20);
    press(20, 20);
    check_eq("wrap_sel", sel, 32'h3);
    btn_base = 1'b1;
    wait_cyc(30);
    check_eq("held_sel", sel, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_sel", sel, 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(40);
    check_eq("held_after_rst", sel, 32'h3);
    btn_base = 1'b0;
    wait_cyc(25);
    check_eq("released_after_rst", sel, 32'h3);
    press(20, 20);
    check_eq("repress_sel", sel, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
